// File: rtl/i2c_mon_pkg.sv
// Purpose : shared definitions for the I2C bus monitor (event codes, record layout, FSM states).
// Latency : n/a (types and helper function only).
// Backpressure: n/a.
package i2c_mon_pkg;

    // Event type codes carried in record bits [15:12]; 0x0 and 0x7-0xF are never produced.
    typedef enum logic [3:0] {
        EVT_START     = 4'h1,
        EVT_RSTART    = 4'h2,
        EVT_ADDR      = 4'h3,
        EVT_DATA      = 4'h4,
        EVT_STOP      = 4'h5,
        EVT_FRAME_ERR = 4'h6
    } evt_type_e;

    // Protocol-tracking FSM states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_SKIP     = 3'd5
    } state_e;

    localparam int EVT_W = 16;

    // Record layout: [15:12] type, [11:10] reserved, [9] ack, [8] r/w, [7:0] byte.
    typedef struct packed {
        evt_type_e  typ;
        logic [1:0] rsvd;
        logic       ack;
        logic       rw;
        logic [7:0] dat;
    } evt_t;

    function automatic logic [EVT_W-1:0] mk_evt(input evt_type_e typ, input logic ack,
                                                 input logic rw, input logic [7:0] dat);
        evt_t e;
        e.typ  = typ;
        e.rsvd = 2'b00;
        e.ack  = ack;
        e.rw   = rw;
        e.dat  = dat;
        return e;
    endfunction

endpackage

// File: rtl/i2c_evt_fifo.sv
// Purpose : generic first-word-fall-through FIFO holding monitor event records.
// Latency : write to o_rd_vld is 1 cycle; head data is visible combinationally.
// Backpressure: a write into a full FIFO is dropped (o_wr_drop pulses) unless a pop happens the same cycle.
// Ports: i_clk/i_rst clock and async reset; i_wr_vld/i_wr_dat write side; o_wr_drop drop pulse;
//        o_rd_vld/o_rd_dat/i_rd_rdy read side (o_rd_dat is 0 while empty).
module i2c_evt_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_vld,
    input  logic [WIDTH-1:0] i_wr_dat,
    output logic             o_wr_drop,
    output logic             o_rd_vld,
    output logic [WIDTH-1:0] o_rd_dat,
    input  logic             i_rd_rdy
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = i_rd_rdy && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = i_wr_vld && (!full || pop);

    assign o_wr_drop = i_wr_vld && full && !pop;
    assign o_rd_vld  = !empty;
    assign o_rd_dat  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_wr_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// Purpose : passive I2C bus monitor that turns START/STOP/address/data activity into 16-bit event records.
// Latency : filtered edge to o_evt_valid is 1 cycle (2 when a FRAME_ERR precedes the START/STOP record).
// Backpressure: records queue in an event FIFO; when full new records are dropped and o_overflow sticks.
// Ports: i_clk/i_rst clock and async reset; i_SDA/i_SCL raw bus pins; o_evt_data/o_evt_valid/i_evt_ready
//        event stream; o_overflow sticky drop flag cleared by i_clr_ovf; o_busy bus-transaction flag.
module i2c_bus_monitor
    import i2c_mon_pkg::*;
#(
    parameter int         FILT_LEN     = 3,
    parameter int         FIFO_DEPTH   = 16,
    parameter int         ADDR_FILT_EN = 0,
    parameter logic [6:0] ADDR_MATCH   = 7'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_SDA,
    input  logic        i_SCL,
    output logic [15:0] o_evt_data,
    output logic        o_evt_valid,
    input  logic        i_evt_ready,
    output logic        o_overflow,
    input  logic        i_clr_ovf,
    output logic        o_busy
);

    localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

    // Pin index 0 = SCL, 1 = SDA.
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      flt;
    logic [1:0]      flt_d;
    logic [1:0][3:0] fcnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= '1;
            sync2 <= '1;
            flt   <= '1;
            flt_d <= '1;
            fcnt  <= '0;
        end else begin
            sync1 <= {i_SDA, i_SCL};
            sync2 <= sync1;
            flt_d <= flt;
            for (int i = 0; i < 2; i++) begin
                // Count consecutive samples disagreeing with the filtered level; any agreeing sample restarts.
                if (sync2[i] != flt[i]) begin
                    if (fcnt[i] == FILT_LAST) begin
                        flt[i]  <= sync2[i];
                        fcnt[i] <= '0;
                    end else begin
                        fcnt[i] <= fcnt[i] + 4'd1;
                    end
                end else begin
                    fcnt[i] <= '0;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_d, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_f     = flt[0];
    assign sda_f     = flt[1];
    assign scl_d     = flt_d[0];
    assign sda_d     = flt_d[1];
    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    // SCL must have been high on both samples so a simultaneous SCL/SDA change is not a bus condition.
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

    state_e      state_q, state_nxt;
    logic [7:0]  shreg_q, shreg_nxt;
    logic [3:0]  cnt_q, cnt_nxt;
    logic [3:0]  hold_q, hold_nxt;
    logic        bit_hi_q, bit_hi_nxt;
    logic        busy_q, busy_nxt;
    logic        pend_start_q, pend_start_nxt;
    logic        pend_stop_q, pend_stop_nxt;
    logic        push_vld;
    logic [15:0] push_dat;
    logic [3:0]  err_cnt;
    logic        fifo_drop;
    logic        ovf_q;

    // Every START/STOP happens during an SCL high phase whose rising edge already shifted a bit in.
    // That bit belongs to the bus condition, not the byte, so the count from before it is used.
    assign err_cnt = bit_hi_q ? hold_q : cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            bit_hi_q     <= 1'b0;
            busy_q       <= 1'b0;
            pend_start_q <= 1'b0;
            pend_stop_q  <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            shreg_q      <= shreg_nxt;
            cnt_q        <= cnt_nxt;
            hold_q       <= hold_nxt;
            bit_hi_q     <= bit_hi_nxt;
            busy_q       <= busy_nxt;
            pend_start_q <= pend_start_nxt;
            pend_stop_q  <= pend_stop_nxt;
        end
    end

    always_comb begin
        state_nxt      = state_q;
        shreg_nxt      = shreg_q;
        cnt_nxt        = cnt_q;
        hold_nxt       = hold_q;
        bit_hi_nxt     = bit_hi_q & ~scl_fall;
        busy_nxt       = busy_q;
        pend_start_nxt = 1'b0;
        pend_stop_nxt  = 1'b0;
        push_vld       = 1'b0;
        push_dat       = '0;

        if (pend_start_q) begin
            // Deferred repeated START after its FRAME_ERR record.
            push_vld  = 1'b1;
            push_dat  = mk_evt(EVT_RSTART, 1'b0, 1'b0, 8'h00);
            state_nxt = ST_ADDR;
        end else if (pend_stop_q) begin
            push_vld  = 1'b1;
            push_dat  = mk_evt(EVT_STOP, 1'b0, 1'b0, 8'h00);
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
        end else if (start_det) begin
            shreg_nxt  = '0;
            cnt_nxt    = '0;
            bit_hi_nxt = 1'b0;
            if (state_q == ST_IDLE) begin
                push_vld  = 1'b1;
                push_dat  = mk_evt(EVT_START, 1'b0, 1'b0, 8'h00);
                busy_nxt  = 1'b1;
                state_nxt = ST_ADDR;
            end else if (err_cnt != 4'd0) begin
                push_vld       = 1'b1;
                push_dat       = mk_evt(EVT_FRAME_ERR, 1'b0, 1'b0, {4'b0000, err_cnt});
                pend_start_nxt = 1'b1;
            end else if (state_q == ST_SKIP) begin
                state_nxt = ST_ADDR;
            end else begin
                push_vld  = 1'b1;
                push_dat  = mk_evt(EVT_RSTART, 1'b0, 1'b0, 8'h00);
                state_nxt = ST_ADDR;
            end
        end else if (stop_det) begin
            if (state_q != ST_IDLE) begin
                shreg_nxt  = '0;
                cnt_nxt    = '0;
                bit_hi_nxt = 1'b0;
                if (err_cnt != 4'd0) begin
                    push_vld      = 1'b1;
                    push_dat      = mk_evt(EVT_FRAME_ERR, 1'b0, 1'b0, {4'b0000, err_cnt});
                    pend_stop_nxt = 1'b1;
                end else begin
                    push_vld  = 1'b1;
                    push_dat  = mk_evt(EVT_STOP, 1'b0, 1'b0, 8'h00);
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
        end else if (scl_rise) begin
            case (state_q)
                ST_ADDR, ST_DATA: begin
                    shreg_nxt  = {shreg_q[6:0], sda_f};
                    hold_nxt   = cnt_q;
                    bit_hi_nxt = 1'b1;
                    if (cnt_q == 4'd7) begin
                        cnt_nxt   = '0;
                        state_nxt = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                    end else begin
                        cnt_nxt = cnt_q + 4'd1;
                    end
                end
                ST_ADDR_ACK: begin
                    if ((ADDR_FILT_EN != 0) && (shreg_q[7:1] != ADDR_MATCH)) begin
                        state_nxt = ST_SKIP;
                    end else begin
                        push_vld  = 1'b1;
                        push_dat  = mk_evt(EVT_ADDR, ~sda_f, shreg_q[0], {1'b0, shreg_q[7:1]});
                        state_nxt = ST_DATA;
                    end
                end
                ST_DATA_ACK: begin
                    push_vld  = 1'b1;
                    push_dat  = mk_evt(EVT_DATA, ~sda_f, 1'b0, shreg_q);
                    state_nxt = ST_DATA;
                end
                default: begin
                end
            endcase
        end
    end

    i2c_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_vld  (push_vld),
        .i_wr_dat  (push_dat),
        .o_wr_drop (fifo_drop),
        .o_rd_vld  (o_evt_valid),
        .o_rd_dat  (o_evt_data),
        .i_rd_rdy  (i_evt_ready)
    );

    // A new drop wins over a clear in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
        end else if (fifo_drop) begin
            ovf_q <= 1'b1;
        end else if (i_clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign o_overflow = ovf_q;
    assign o_busy     = busy_q;

endmodule
